// File: rtl/seq_movebit_unit_if.sv
// Handshake and data bundle between the E-stage controller and the popcount shift unit.
interface seq_movebit_unit_if #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
);
  localparam int CW = $clog2(IMM_W + 1);

  logic             start;
  logic             flush;
  logic [1:0]       mode;
  logic [WIDTH-1:0] src;
  logic [IMM_W-1:0] imm;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    count;

  modport master (
    output start, flush, mode, src, imm,
    input  busy, done, result, count
  );

  modport slave (
    input  start, flush, mode, src, imm,
    output busy, done, result, count
  );
endinterface

// File: rtl/seq_movebit_unit.sv
// Multi-cycle popcount-driven shift unit: shifts one bit per cycle by popcount(imm)
// in one of four modes, behind a start/busy/done handshake with flush abort.
module seq_movebit_unit #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  seq_movebit_unit_if.slave  bus
);
  localparam int CW = $clog2(IMM_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] MODE_FLIPSRA = 2'd0;
  localparam logic [1:0] MODE_SRA     = 2'd1;
  localparam logic [1:0] MODE_SRL     = 2'd2;
  localparam logic [1:0] MODE_ROTR    = 2'd3;

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  logic [1:0]       state;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    remain;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    count_q;

  logic [CW-1:0]    pc;
  logic [WIDTH-1:0] prep;
  logic [WIDTH-1:0] flip_mask;
  logic [WIDTH-1:0] stepped;
  logic             accept;

  // Population count of the incoming immediate (the shift amount).
  always_comb begin
    pc = '0;
    for (int unsigned i = 0; i < IMM_W; i++) begin
      pc = pc + CW'(bus.imm[i]);
    end
  end

  // Operand preparation at accept: FLIPSRA inverts the top pc bits, or all bits when imm >= WIDTH.
  always_comb begin
    flip_mask = ~({WIDTH{1'b1}} >> pc);
    prep      = bus.src;
    if (bus.mode == MODE_FLIPSRA) begin
      if (WIDTH'(bus.imm) < WIDTH_V) begin
        prep = bus.src ^ flip_mask;
      end else begin
        prep = ~bus.src;
      end
    end
  end

  // One-bit step of the working value according to the latched mode.
  always_comb begin
    stepped = {work[WIDTH-1], work[WIDTH-1:1]};
    case (mode_q)
      MODE_SRL:  stepped = {1'b0, work[WIDTH-1:1]};
      MODE_ROTR: stepped = {work[0], work[WIDTH-1:1]};
      MODE_FLIPSRA,
      MODE_SRA:  stepped = {work[WIDTH-1], work[WIDTH-1:1]};
      default:   stepped = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

  assign accept = bus.start && !bus.flush && (state == ST_IDLE || state == ST_DONE);

  // Sequencer: accept/capture, per-cycle shifting, completion and flush abort.
  // A zero-popcount op skips SHIFT, so its result is written at the accept edge
  // to be valid alongside the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      mode_q   <= '0;
      work     <= '0;
      remain   <= '0;
      result_q <= '0;
      count_q  <= '0;
    end else if (bus.flush) begin
      state <= ST_IDLE;
    end else if (accept) begin
      count_q <= pc;
      remain  <= pc;
      mode_q  <= bus.mode;
      work    <= prep;
      if (pc == '0) begin
        result_q <= prep;
        state    <= ST_DONE;
      end else begin
        state <= ST_SHIFT;
      end
    end else begin
      case (state)
        ST_SHIFT: begin
          work   <= stepped;
          remain <= remain - CW'(1);
          if (remain == CW'(1)) begin
            result_q <= stepped;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == ST_SHIFT);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = result_q;
  assign bus.count  = count_q;
endmodule

// File: tb/tb_seq_movebit_unit.sv
// Directed self-checking bench for seq_movebit_unit (WIDTH=32, IMM_W=16).
module tb_seq_movebit_unit;
  logic clk;
  logic reset;
  int   passed;
  int   total;

  seq_movebit_unit_if #(.WIDTH(32), .IMM_W(16)) bus ();

  seq_movebit_unit #(.WIDTH(32), .IMM_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] m, input logic [31:0] s, input logic [15:0] i);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.src   = s;
    bus.imm   = i;
  endtask

  // Called at the negedge where start is already driven; follows the op through done.
  task automatic follow(input string tag, input int k, input logic [31:0] exp_res);
    @(negedge clk);
    bus.start = 1'b0;
    bus.src   = 32'hDEAD_BEEF;
    bus.imm   = 16'hAAAA;
    for (int j = 0; j <= k; j++) begin
      if (j > 0) @(negedge clk);
      check($sformatf("%s_busy%0d", tag, j), {31'b0, bus.busy}, {31'b0, (j < k)});
      check($sformatf("%s_done%0d", tag, j), {31'b0, bus.done}, {31'b0, (j == k)});
    end
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_count"}, {27'b0, bus.count}, k);
  endtask

  task automatic run_op(input string tag, input logic [1:0] m, input logic [31:0] s,
                        input logic [15:0] i, input int k, input logic [31:0] exp_res);
    @(negedge clk);
    drive(m, s, i);
    follow(tag, k, exp_res);
  endtask

  initial begin
    bit seen_done;
    passed    = 0;
    total     = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.mode  = 2'd0;
    bus.src   = '0;
    bus.imm   = '0;

    #2;
    check("rst_busy",   {31'b0, bus.busy}, 32'd0);
    check("rst_done",   {31'b0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_count",  {27'b0, bus.count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // FLIPSRA: top 2 bits flipped -> 0x4000_0000, then 2 arithmetic steps
    run_op("flip3", 2'd0, 32'h8000_0000, 16'h0003, 2, 32'h1000_0000);
    // zero popcount: done next cycle, busy never
    run_op("flip0", 2'd0, 32'h1234_5678, 16'h0000, 0, 32'h1234_5678);
    // imm >= WIDTH: invert all -> 0xFFFF_FFF0, 8 SRA steps
    run_op("flipff", 2'd0, 32'h0000_000F, 16'h00FF, 8, 32'hFFFF_FFFF);
    run_op("rotr", 2'd3, 32'h0000_0001, 16'h0001, 1, 32'h8000_0000);
    run_op("srl16", 2'd2, 32'h8000_0000, 16'hFFFF, 16, 32'h0000_8000);
    run_op("sra16", 2'd1, 32'h8000_0000, 16'hFFFF, 16, 32'hFFFF_8000);

    // start pulsed during SHIFT is ignored
    @(negedge clk);
    drive(2'd2, 32'h0000_00F0, 16'h000F);
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_busy0", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    drive(2'd3, 32'h0000_0001, 16'h0001);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("ign_busy3", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    check("ign_done", {31'b0, bus.done}, 32'd1);
    check("ign_result", bus.result, 32'h0000_000F);
    check("ign_count", {27'b0, bus.count}, 32'd4);
    @(negedge clk);
    check("ign_idle_busy", {31'b0, bus.busy}, 32'd0);
    check("ign_idle_done", {31'b0, bus.done}, 32'd0);

    // flush on 2nd SHIFT cycle aborts: no done, result kept
    @(negedge clk);
    drive(2'd2, 32'hFFFF_0000, 16'h000F);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("fl_busy_pre", {31'b0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("fl_busy", {31'b0, bus.busy}, 32'd0);
    check("fl_done", {31'b0, bus.done}, 32'd0);
    seen_done = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    check("fl_no_done", {31'b0, seen_done}, 32'd0);
    check("fl_result", bus.result, 32'h0000_000F);

    // flush and start together: flush wins
    drive(2'd2, 32'h0000_0100, 16'h0001);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flst_busy", {31'b0, bus.busy}, 32'd0);
    check("flst_done", {31'b0, bus.done}, 32'd0);

    // back-to-back: new start during DONE cycle
    run_op("b2b_a", 2'd2, 32'h0000_0100, 16'h0001, 1, 32'h0000_0080);
    drive(2'd3, 32'h0000_0002, 16'h0001);
    follow("b2b_b", 1, 32'h0000_0001);

    // reset mid-SHIFT
    @(negedge clk);
    drive(2'd2, 32'h8000_0000, 16'hFFFF);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mrst_busy",   {31'b0, bus.busy}, 32'd0);
    check("mrst_done",   {31'b0, bus.done}, 32'd0);
    check("mrst_result", bus.result, 32'd0);
    check("mrst_count",  {27'b0, bus.count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen_done = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    check("mrst_quiet", {31'b0, seen_done}, 32'd0);

    run_op("post_rst", 2'd2, 32'h8000_0000, 16'h0100, 1, 32'h4000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
